pipe_perf_monitor: RTL

Hardware performance monitor that sits downstream of the pipelined CPU core and samples its hazard, flush and control signals every cycle. It replaces bench-only bookkeeping for cycle, stall and flush counts with synthesizable counters. It adds a readout port and a programmable run-length halt, so the same statistics are available on silicon and in simulation.

---
 rtl/perf_pkg.sv | 32 +++
 rtl/pipe_perf_monitor_if.sv | 45 ++++
 rtl/pipe_perf_monitor_sat_counter.sv | 47 ++++
 rtl/pipe_perf_monitor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Shared definitions for the pipeline performance monitor:
//               FSM state encoding, readout select codes and the default
//               counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

    // Default width of every event counter and of the readout bus
    localparam int DEF_CNT_W = 32;

    // Monitor FSM state encoding (visible on state_o)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Readout select codes for sel_i
    localparam logic [2:0] SEL_CYCLE      = 3'd0;
    localparam logic [2:0] SEL_STALL      = 3'd1;
    localparam logic [2:0] SEL_FLUSH      = 3'd2;
    localparam logic [2:0] SEL_RETIRE     = 3'd3;
    localparam logic [2:0] SEL_PC         = 3'd4;
    localparam logic [2:0] SEL_LAST_FLUSH = 3'd5;
    localparam logic [2:0] SEL_STATUS     = 3'd6;
    localparam logic [2:0] SEL_STALLRUN   = 3'd7;

endpackage : perf_pkg
`default_nettype wire

// File: rtl/pipe_perf_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_monitor_if
// Description : Bundles the core event inputs and the readout outputs of the
//               performance monitor.
//               master : core / host side (drives events and sel_i)
//               slave  : monitor side (drives data_o, halt_o, state_o)
//               Events : start_i, clear_i, stall_i, is_jump_i, is_branch_i,
//                        flush_i, retire_i, pc_i[PC_W]
//               Readout: sel_i[3] -> data_o[CNT_W], halt_o, state_o[2]
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_perf_monitor_if
    import perf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PC_W  = 32
);
    logic             start_i;
    logic             clear_i;
    logic             stall_i;
    logic             is_jump_i;
    logic             is_branch_i;
    logic             flush_i;
    logic             retire_i;
    logic [PC_W-1:0]  pc_i;
    logic [2:0]       sel_i;
    logic [CNT_W-1:0] data_o;
    logic             halt_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, clear_i, stall_i, is_jump_i, is_branch_i,
               flush_i, retire_i, pc_i, sel_i,
        input  data_o, halt_o, state_o
    );

    modport slave (
        input  start_i, clear_i, stall_i, is_jump_i, is_branch_i,
               flush_i, retire_i, pc_i, sel_i,
        output data_o, halt_o, state_o
    );

endinterface : pipe_perf_monitor_if
`default_nettype wire

// File: rtl/pipe_perf_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones instead of wrapping.
//               clk_i : clock
//               rst_i : synchronous reset, active-low
//               clr_i : synchronous clear (wins over inc_i)
//               inc_i : count enable
//               q_o   : current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import perf_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic         clr_i,
    input  wire logic         inc_i,
    output logic      [W-1:0] q_o
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_monitor
// Description : Pipeline performance monitor. Counts cycles, non-control
//               stalls, flushes and retired instructions while in RUN,
//               records the PC of the last flush and halts after
//               HALT_CYCLES run cycles (0 = never). Readout is registered
//               with one cycle of latency.
//               clk_i : clock
//               rst_i : synchronous reset, active-low
//               bus   : pipe_perf_monitor_if.slave (events in, readout out)
//               Optional macro PERF_STALL_RUN_EN adds longest-stall-run
//               tracking readable on select 7 (reads 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PC_W        = 32,
    parameter int HALT_CYCLES = 30
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    pipe_perf_monitor_if.slave bus
);

    // Halt target widened by one bit so HALT_CYCLES = 2^CNT_W can never match
    localparam logic [CNT_W:0] c_halt_at = (CNT_W+1)'(HALT_CYCLES);

    state_t            state_q, state_d;
    logic              halt_q, halt_d;
    logic [CNT_W-1:0]  data_q, data_d;
    logic [PC_W-1:0]   last_flush_pc_q, last_flush_pc_d;

    logic [CNT_W-1:0]  cycle_cnt, stall_cnt, flush_cnt, retire_cnt;
    logic [CNT_W-1:0]  w_pc_ext, w_lfp_ext;
    logic [CNT_W:0]    w_cycle_inc;
    logic              w_run, w_qual_stall, w_halt_hit;

    assign w_run        = (state_q == ST_RUN);
    // Stalls caused by jumps/branches are control penalties, not hazards
    assign w_qual_stall = bus.stall_i & ~bus.is_jump_i & ~bus.is_branch_i;
    // Post-increment cycle count, saturated like the counter itself
    assign w_cycle_inc  = (cycle_cnt == '1) ? {1'b0, cycle_cnt}
                                            : {1'b0, cycle_cnt} + (CNT_W+1)'(1);
    assign w_halt_hit   = (HALT_CYCLES != 0) && (w_cycle_inc == c_halt_at);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
        .inc_i(w_run), .q_o(cycle_cnt)
    );
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
        .inc_i(w_run & w_qual_stall), .q_o(stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
        .inc_i(w_run & bus.flush_i), .q_o(flush_cnt)
    );
    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(bus.clear_i),
        .inc_i(w_run & bus.retire_i), .q_o(retire_cnt)
    );

`ifdef PERF_STALL_RUN_EN
    logic [CNT_W-1:0] cur_run;
    logic [CNT_W-1:0] w_cur_run_inc;
    logic [CNT_W-1:0] max_run_q, max_run_d;

    // A non-stall RUN cycle ends the current run
    sat_counter #(.W(CNT_W)) u_cur_run (
        .clk_i(clk_i), .rst_i(rst_i),
        .clr_i(bus.clear_i | (w_run & ~w_qual_stall)),
        .inc_i(w_run & w_qual_stall), .q_o(cur_run)
    );

    always_comb begin
        w_cur_run_inc = (cur_run == '1) ? cur_run : cur_run + CNT_W'(1);
        max_run_d     = max_run_q;
        if (bus.clear_i) begin
            max_run_d = '0;
        end else if (w_run && w_qual_stall && (w_cur_run_inc > max_run_q)) begin
            max_run_d = w_cur_run_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            max_run_q <= '0;
        end else begin
            max_run_q <= max_run_d;
        end
    end
`endif

    generate
        if (PC_W >= CNT_W) begin : g_pc_trunc
            assign w_pc_ext  = bus.pc_i[CNT_W-1:0];
            assign w_lfp_ext = last_flush_pc_q[CNT_W-1:0];
        end else begin : g_pc_zext
            assign w_pc_ext  = {{(CNT_W-PC_W){1'b0}}, bus.pc_i};
            assign w_lfp_ext = {{(CNT_W-PC_W){1'b0}}, last_flush_pc_q};
        end
    endgenerate

    // FSM next state; clear returns to IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start_i) state_d = ST_RUN;
                ST_RUN:  if (w_halt_hit)  state_d = ST_HALT;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        halt_d          = (state_d == ST_HALT);
        last_flush_pc_d = last_flush_pc_q;
        if (bus.clear_i) begin
            last_flush_pc_d = '0;
        end else if (w_run && bus.flush_i) begin
            last_flush_pc_d = bus.pc_i;
        end
    end

    // Readout samples values as they stand before this edge
    always_comb begin
        data_d = '0;
        case (bus.sel_i)
            SEL_CYCLE:      data_d = cycle_cnt;
            SEL_STALL:      data_d = stall_cnt;
            SEL_FLUSH:      data_d = flush_cnt;
            SEL_RETIRE:     data_d = retire_cnt;
            SEL_PC:         data_d = w_pc_ext;
            SEL_LAST_FLUSH: data_d = w_lfp_ext;
            SEL_STATUS:     data_d = CNT_W'({halt_q, state_q});
`ifdef PERF_STALL_RUN_EN
            SEL_STALLRUN:   data_d = max_run_q;
`else
            SEL_STALLRUN:   data_d = '0;
`endif
            default:        data_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q         <= ST_IDLE;
            halt_q          <= 1'b0;
            data_q          <= '0;
            last_flush_pc_q <= '0;
        end else begin
            state_q         <= state_d;
            halt_q          <= halt_d;
            data_q          <= data_d;
            last_flush_pc_q <= last_flush_pc_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.halt_o  = halt_q;
    assign bus.state_o = state_q;

endmodule : pipe_perf_monitor
`default_nettype wire
